// File: rtl/aes_sbox_pkg.sv
// Shared AES byte-transform definitions: mode encodings, GF(2^8) helpers and
// the forward/inverse S-box as closed-form functions of the input byte.
package aes_sbox_pkg;

    typedef enum logic [1:0] {
        MODE_S   = 2'd0,
        MODE_XS  = 2'd1,
        MODE_X3S = 2'd2,
        MODE_INV = 2'd3
    } mode_t;

    localparam logic [7:0] AES_POLY     = 8'h1B;
    localparam logic [7:0] AFFINE_C     = 8'h63;
    localparam logic [7:0] INV_AFFINE_C = 8'h05;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (a^254 = a^2 * a^4 * ... * a^128); zero maps to zero.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] base;
        r    = 8'h01;
        base = a;
        for (int i = 1; i < 8; i++) begin
            base = gf_mul(base, base);
            r    = gf_mul(r, base);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        logic [7:0] x;
        x = gf_inv(b);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ AFFINE_C;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] s);
        logic [7:0] x;
        x = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ INV_AFFINE_C;
        return gf_inv(x);
    endfunction

endpackage

// File: rtl/sbox_rom.sv
// Combinational per-byte lookup giving both the forward and inverse AES S-box.
module sbox_rom
    import aes_sbox_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] fwd,
    output logic [7:0] inv
);

    assign fwd = sbox_fwd(din);
    assign inv = sbox_inv(din);

endmodule

// File: rtl/sbox_pipe.sv
// Two-stage valid/ready pipeline applying an AES S-box based transform to
// every byte lane, carrying a sideband tag alongside each transfer.
module sbox_pipe
    import aes_sbox_pkg::*;
#(
    parameter int LANES = 4,
    parameter int TAG_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [8*LANES-1:0]   in_data,
    input  logic [1:0]           in_mode,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8*LANES-1:0]   out_data,
    output logic [TAG_W-1:0]     out_tag
);

    logic                 s1_valid;
    logic [8*LANES-1:0]   s1_data;
    mode_t                s1_mode;
    logic [TAG_W-1:0]     s1_tag;

    logic                 s2_valid;
    logic [8*LANES-1:0]   s2_data;
    logic [TAG_W-1:0]     s2_tag;

    logic                 s2_load;
    logic                 s1_load;
    logic [8*LANES-1:0]   xform;

    // Each stage advances whenever the one downstream frees up, so bubbles collapse.
    assign s2_load  = !s2_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load && !rst;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [7:0] fwd_b;
        logic [7:0] inv_b;
        logic [7:0] lane_out;

        sbox_rom u_rom (
            .din (s1_data[8*i +: 8]),
            .fwd (fwd_b),
            .inv (inv_b)
        );

        always_comb begin
            lane_out = fwd_b;
            case (s1_mode)
                MODE_S:   lane_out = fwd_b;
                MODE_XS:  lane_out = xtime(fwd_b);
                MODE_X3S: lane_out = xtime(fwd_b) ^ fwd_b;
                MODE_INV: lane_out = inv_b;
                default:  lane_out = fwd_b;
            endcase
        end

        assign xform[8*i +: 8] = lane_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= MODE_S;
            s1_tag   <= '0;
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_tag   <= '0;
        end else begin
            if (s1_load) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_data <= in_data;
                    s1_mode <= mode_t'(in_mode);
                    s1_tag  <= in_tag;
                end
            end
            // Payload only moves with a real transfer so a stalled output stays put.
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= xform;
                    s2_tag  <= s1_tag;
                end
            end
        end
    end

    assign out_valid = s2_valid;
    assign out_data  = s2_data;
    assign out_tag   = s2_tag;

endmodule

// File: doc/sbox_pipe.md
SBOX_PIPE -- requirements
Module: sbox_pipe

Interface
REQ-001 Parameter LANES, default 4: number of independent byte lanes processed per transfer (1..16).
REQ-002 Parameter TAG_W, default 8: width of the opaque sideband tag carried alongside each transfer (>=1).
REQ-003 Port clk  input  1  the only clock; all state updates on its rising edge.
REQ-004 Port rst  input  1  reset, synchronous and active-high.
REQ-005 Port in_valid  input  1  input transfer offered.
REQ-006 Port in_ready  output  1  block accepts input this cycle.
REQ-007 Port in_data  input  8*LANES  input bytes; lane i occupies bits [8i+7:8i].
REQ-008 Port in_mode  input  2  transform select: 0=S, 1=2*S, 2=3*S, 3=S^-1.
REQ-009 Port in_tag  input  TAG_W  sideband, returned unmodified with the result.
REQ-010 Port out_valid  output  1  result transfer offered.
REQ-011 Port out_ready  input  1  downstream accepts the result.
REQ-012 Port out_data  output  8*LANES  transformed bytes, same lane mapping as in_data.
REQ-013 Port out_tag  output  TAG_W  tag of the transfer presented on out_data.

Function
REQ-014 A transfer occurs on a port in any cycle where valid and ready are both high; no other cycle moves data.
REQ-015 Mode 0: each lane outputs the AES forward S-box of its input byte.
REQ-016 Mode 1: each lane outputs xtime(S(b)), i.e. S(b)<<1, XORed with 0x1B when bit 7 of S(b) is set; result truncated to 8 bits.
REQ-017 Mode 2: each lane outputs xtime(S(b)) XOR S(b).
REQ-018 Mode 3: each lane outputs the AES inverse S-box of its input byte.
REQ-019 Mode and tag are sampled with the data and apply to that transfer only; consecutive transfers may use different modes.
REQ-020 Two register stages: stage 1 holds accepted data/mode/tag; stage 2 holds the transformed result and drives out_*.
REQ-021 Latency with out_ready held high: a transfer accepted in cycle N appears with out_valid high in cycle N+2.
REQ-022 Stage 2 loads when it is empty or out_ready is high; stage 1 loads when it is empty or stage 2 loads.
REQ-023 in_ready is high when stage 1 is empty or stage 2 loads in the same cycle, so empty stages collapse and a stalled pipe absorbs at most 2 transfers.
REQ-024 Sustained throughput is one transfer per cycle while in_valid and out_ready are both high.
REQ-025 While out_valid is high and out_ready is low, out_data and out_tag hold stable until the transfer completes.
REQ-026 Results leave in acceptance order; none is dropped or duplicated under any valid/ready pattern.
REQ-027 in_ready has no combinational path from in_valid; it depends only on internal state and out_ready.

Reset
REQ-028 While rst is high, both stage valid flags clear, out_valid=0, out_data=0, out_tag=0, and in_ready=0.
REQ-029 in_ready goes high in the first cycle after rst deasserts.
REQ-030 Asserting rst mid-operation discards all in-flight transfers; no result of a pre-reset transfer appears after reset.

Structure
REQ-031 Mode encodings (MODE_S, MODE_XS, MODE_X3S, MODE_INV) and the reduction constant 8'h1B are defined in the shared package aes_sbox_pkg.
REQ-032 The per-byte lookup is the combinational sub-module sbox_rom (8-bit in; forward and inverse 8-bit outs), instantiated once per lane.
REQ-033 The xtime/XOR mode mux sits in sbox_pipe, between sbox_rom and the stage-2 register.

Verification
REQ-034 Reset, then in_data=0x00 in all lanes with modes 0,1,2,3 back-to-back and out_ready=1 -> outputs 0x63, 0xC6, 0xA5, 0x52 in cycles N+2..N+5.
REQ-035 LANES=4, in_data=0x53_01_00_FF, mode 1 -> out_data=0xC1_F8_C6_2C.
REQ-036 Mode 0 on byte b, then mode 3 on the result, swept over all 256 b -> each final output equals b.
REQ-037 out_ready low for 5 cycles while in_valid stays high with tags 1,2,3 -> exactly 2 transfers accepted, in_ready low; after release, tags 1,2,3 emerge in order with no gap.
REQ-038 Random in_valid/out_ready (50% each) for 10k transfers against a reference model -> order, data and tags match; out_data is stable while stalled.
REQ-039 rst pulsed one cycle with 2 transfers in flight -> out_valid=0 the next cycle; the first post-reset output is the first post-reset input.
